mux_2_to_1_arbiter: RTL and testbench
=====================================

# mux_2_to_1_arbiter

Sequencer for the shared 2-to-1 one-bit datapath: two requesters (x, y) compete for one output bit, and this block drives the mux select. It arbitrates round-robin, bounds grant tenure, and registers the selected bit with a valid flag. It sits between two single-bit producers and one shared consumer line.

## Interface

Parameters:
- HOLD_MAX, default 4: maximum consecutive grant cycles while the other requester waits. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- x_req  input  1  requester x wants the line
- y_req  input  1  requester y wants the line
- x_data  input  1  requester x data bit
- y_data  input  1  requester y data bit
- s  output  1  mux select: 1 routes x, 0 routes y
- x_gnt  output  1  x owns the line this cycle
- y_gnt  output  1  y owns the line this cycle
- m  output  1  registered selected bit
- m_valid  output  1  m holds a bit captured under a grant

## Operation

- Reset (rst=1 at an edge): state IDLE, s=0, x_gnt=0, y_gnt=0, m=0, m_valid=0, hold counter=0, last=Y, so x wins the first tie. rst overrides all other inputs, including mid-grant.
- States: IDLE, GX, GY. Outputs are Moore-decoded from state:
  - GX: x_gnt=1, s=1.
  - GY: y_gnt=1, s=0.
  - IDLE: both grants 0, s holds its last value.
- IDLE:
  - only x_req -> GX.
  - only y_req -> GY.
  - both -> the side opposite `last`.
  - none -> stay in IDLE.
- GX (GY is symmetric):
  - x_req=0 and y_req=1 -> GY.
  - x_req=0 and y_req=0 -> IDLE.
  - x_req=1, y_req=1, counter==HOLD_MAX-1 -> GY (forced handoff).
  - otherwise stay in GX.
- Hold counter, 8 bits:
  - cleared on every transition into GX or GY.
  - incremented each cycle the state stays in GX or GY.
  - saturates at 255.
- `last` updates to X on entry to GX and to Y on entry to GY.
- Datapath, every edge:
  - m <= (s ? x_data : y_data) when the state is GX or GY; otherwise m holds.
  - m_valid <= 1 when the state is GX or GY, else 0.

## Timing

- Request to grant: a request sampled at edge n gives a grant asserted after edge n, i.e. in cycle n+1.
- Grant to data: data driven while a grant is high is captured at the next edge, so m/m_valid lag the grant by exactly 1 cycle.
- GX<->GY handoff has no IDLE bubble: one-cycle turnaround, and grants are never both high.
- Forced handoff: with both requesting continuously, each side holds exactly HOLD_MAX cycles and then alternates. HOLD_MAX=1 alternates every cycle.
- A requester dropping req in the same cycle as a forced handoff changes nothing: the other side is still granted.
- Reset asserted mid-grant: grants drop and m_valid=0 after that edge. First grant after reset release follows the IDLE rules with last=Y.

## Configuration

- MUX_ARB_HOLD_LIMIT_EN:
  - Defined: forced handoff at HOLD_MAX as described.
  - Undefined: the counter and forced handoff are removed, and a grant persists until its req drops (HOLD_MAX ignored). Round-robin tie-break in IDLE and on drop is unchanged.

## Test plan

- Reset: rst=1 for 2 cycles with x_req=y_req=1 -> s=0, gnts=0, m=0, m_valid=0. After release, x_gnt=1 in the next cycle and s=1.
- Single requester: y_req=1 with y_data toggling 1,0,1 -> y_gnt=1 one cycle after the req. m follows y_data one cycle behind the grant, with m_valid=1 throughout.
- Contention, HOLD_MAX=4, macro defined: x_req=y_req=1 held for 20 cycles -> grant pattern X×4, Y×4, X×4…, no overlapping grants, no idle gaps.
- Drop handoff: GX active, x_req falls while y_req=1 -> y_gnt=1 the very next cycle. Then y_req falls with x_req=0 -> IDLE and m_valid=0 one cycle later.
- Reset mid-grant: GY with HOLD counter at 2, rst pulse -> y_gnt=0 and m_valid=0 after the edge. With x_req=y_req=1 afterward, x is granted first.
- Macro undefined: x_req=y_req=1 for 12 cycles -> x_gnt stays 1 all 12 cycles. When x_req drops, y_gnt=1 the next cycle.

Source files
------------

// File: rtl/mux_2_to_1_arbiter.sv
// Round-robin arbiter driving the select of a shared 2-to-1 one-bit datapath, with registered output.
// Define MUX_ARB_HOLD_LIMIT_EN to bound grant tenure to HOLD_MAX cycles under contention.
module mux_2_to_1_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic x_req,
  input  logic y_req,
  input  logic x_data,
  input  logic y_data,
  output logic s,
  output logic x_gnt,
  output logic y_gnt,
  output logic m,
  output logic m_valid
);

  typedef enum logic [1:0] {StIdle, StGx, StGy} state_e;

  state_e state_q, state_d;
  logic   last_x_q, last_x_d;  // 1: x held the line most recently
  logic   s_q, s_d;
  logic   m_q, m_valid_q;
  logic   hold_expired;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : gen_hold_check
    $error("HOLD_MAX must be in 1..255");
  end

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  logic [7:0] cnt_q, cnt_d;

  assign hold_expired = (cnt_q == HoldLast);

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != StIdle) begin
      if (state_d != state_q) begin
        cnt_d = 8'd0;
      end else if (cnt_q != 8'hff) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (x_req && y_req) begin
          state_d = last_x_q ? StGy : StGx;
        end else if (x_req) begin
          state_d = StGx;
        end else if (y_req) begin
          state_d = StGy;
        end
      end
      StGx: begin
        if (!x_req) begin
          state_d = y_req ? StGy : StIdle;
        end else if (y_req && hold_expired) begin
          state_d = StGy;
        end
      end
      StGy: begin
        if (!y_req) begin
          state_d = x_req ? StGx : StIdle;
        end else if (x_req && hold_expired) begin
          state_d = StGx;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Select and round-robin history follow the granted side; both hold through IDLE.
  always_comb begin
    last_x_d = last_x_q;
    s_d      = s_q;
    if (state_d == StGx) begin
      last_x_d = 1'b1;
      s_d      = 1'b1;
    end else if (state_d == StGy) begin
      last_x_d = 1'b0;
      s_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_x_q  <= 1'b0;
      s_q       <= 1'b0;
      m_q       <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_x_q  <= last_x_d;
      s_q       <= s_d;
      m_valid_q <= (state_q != StIdle);
      if (state_q != StIdle) begin
        m_q <= s_q ? x_data : y_data;
      end
    end
  end

  assign s       = s_q;
  assign x_gnt   = (state_q == StGx);
  assign y_gnt   = (state_q == StGy);
  assign m       = m_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_mux_2_to_1_arbiter.sv
// Directed self-checking bench for mux_2_to_1_arbiter; adapts contention checks to
// MUX_ARB_HOLD_LIMIT_EN.
module tb_mux_2_to_1_arbiter;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst, x_req, y_req, x_data, y_data;
  logic s, x_gnt, y_gnt, m, m_valid;
  int   checks = 0;
  int   errors = 0;

  mux_2_to_1_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .x_req   (x_req),
    .y_req   (y_req),
    .x_data  (x_data),
    .y_data  (y_data),
    .s       (s),
    .x_gnt   (x_gnt),
    .y_gnt   (y_gnt),
    .m       (m),
    .m_valid (m_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; x_req = 1'b1; y_req = 1'b1; x_data = 1'b1; y_data = 1'b1;
    tick();
    tick();
    checks++;
    if ({s, x_gnt, y_gnt, m, m_valid} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state: s/xg/yg/m/mv=%b required 00000", {s, x_gnt, y_gnt, m, m_valid});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({x_gnt, y_gnt, s, m_valid} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_first_grant: xg/yg/s/mv=%b required 1010", {x_gnt, y_gnt, s, m_valid});
    end
    tick();
    checks++;
    if ({m, m_valid} !== 2'b11) begin
      errors++;
      $display("FAIL reset_first_data: m/mv=%b required 11", {m, m_valid});
    end
    x_req = 1'b0; y_req = 1'b0;
    tick();
    tick();
    // Idle after an x grant keeps the select at x.
    checks++;
    if ({x_gnt, y_gnt, s, m_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL idle_hold_s: xg/yg/s/mv=%b required 0010", {x_gnt, y_gnt, s, m_valid});
    end
  endtask

  task automatic test_single();
    logic [2:0] pat;
    pat = 3'b101;
    x_data = 1'b0; y_data = 1'b0; y_req = 1'b1;
    tick();
    checks++;
    if ({x_gnt, y_gnt, s, m_valid} !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: xg/yg/s/mv=%b required 0100", {x_gnt, y_gnt, s, m_valid});
    end
    for (int i = 0; i < 3; i++) begin
      y_data = pat[2-i];
      x_data = ~pat[2-i];
      tick();
      checks++;
      if ({m, m_valid, y_gnt} !== {pat[2-i], 2'b11}) begin
        errors++;
        $display("FAIL single_data[%0d]: m/mv/yg=%b required %b", i, {m, m_valid, y_gnt},
                 {pat[2-i], 2'b11});
      end
    end
    y_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({y_gnt, m_valid, m} !== 3'b001) begin
      errors++;
      $display("FAIL single_idle: yg/mv/m=%b required 001", {y_gnt, m_valid, m});
    end
  endtask

  task automatic test_drop();
    x_req = 1'b1; y_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({x_gnt, y_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL drop_gx: xg/yg=%b required 10", {x_gnt, y_gnt});
    end
    x_req = 1'b0; y_req = 1'b1;
    tick();
    checks++;
    if ({x_gnt, y_gnt, s} !== 3'b010) begin
      errors++;
      $display("FAIL drop_handoff: xg/yg/s=%b required 010", {x_gnt, y_gnt, s});
    end
    y_req = 1'b0;
    tick();
    checks++;
    if ({x_gnt, y_gnt, m_valid} !== 3'b001) begin
      errors++;
      $display("FAIL drop_idle: xg/yg/mv=%b required 001", {x_gnt, y_gnt, m_valid});
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_valid_low: m_valid=%b required 0", m_valid);
    end
  endtask

  task automatic test_contention();
    int   n;
    logic exp_x, prev_x;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    n = 20;
`else
    n = 12;
`endif
    prev_x = 1'b0;
    x_data = 1'b1; y_data = 1'b0; x_req = 1'b1; y_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
`ifdef MUX_ARB_HOLD_LIMIT_EN
      exp_x = ((i / HOLD) % 2) == 0;
`else
      exp_x = 1'b1;
`endif
      checks++;
      if ({x_gnt, y_gnt} !== {exp_x, ~exp_x}) begin
        errors++;
        $display("FAIL contention_gnt[%0d]: xg/yg=%b required %b", i, {x_gnt, y_gnt},
                 {exp_x, ~exp_x});
      end
      if (i > 0) begin
        checks++;
        if ({m, m_valid} !== {prev_x, 1'b1}) begin
          errors++;
          $display("FAIL contention_data[%0d]: m/mv=%b required %b", i, {m, m_valid},
                   {prev_x, 1'b1});
        end
      end
      prev_x = exp_x;
    end
    x_req = 1'b0;
    tick();
    checks++;
    if ({x_gnt, y_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL contention_release: xg/yg=%b required 01", {x_gnt, y_gnt});
    end
  endtask

  task automatic test_reset_mid();
    y_req = 1'b0;
    tick();
    tick();
    y_req = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (y_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup_gy: y_gnt=%b required 1", y_gnt);
    end
    rst = 1'b1; x_req = 1'b1;
    tick();
    checks++;
    if ({x_gnt, y_gnt, m_valid, s, m} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_reset_gy: xg/yg/mv/s/m=%b required 00000",
               {x_gnt, y_gnt, m_valid, s, m});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({x_gnt, y_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL mid_after_gy: xg/yg=%b required 10", {x_gnt, y_gnt});
    end
    // Now in GX with x most recent; reset must still restore x priority.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({x_gnt, y_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL mid_after_gx: xg/yg=%b required 10", {x_gnt, y_gnt});
    end
  endtask

  initial begin
    rst = 1'b1; x_req = 1'b0; y_req = 1'b0; x_data = 1'b0; y_data = 1'b0;
    test_reset();
    test_single();
    test_drop();
    test_contention();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
